// File: rtl/fixed_mult_arbiter.sv
// fixed_mult_arbiter
//   Round-robin front end for a single pipelined signed fixed-point multiplier
//   shared by NUM_REQ requesters. Up to one operand pair is accepted per cycle.
//   Each result comes back PIPE_STAGES cycles after its accept cycle, tagged
//   with the index of the requester that issued it. The pipeline never stalls.
//
//   Result format is Q(TOTAL_PREC-FRAC_BITS).FRAC_BITS. The product is
//   truncated toward negative infinity (the low FRAC_BITS bits are dropped).
//   By default an out-of-range product wraps.
//
//   Optional build macro:
//     FIXED_MULT_SAT_EN - an out-of-range product clamps to the most positive
//                         or most negative representable value, selected by
//                         the sign of the full-width product. Latency is the
//                         same in both builds.
module fixed_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TOTAL_PREC  = 27,
  parameter int FRAC_BITS   = 22,
  parameter int PIPE_STAGES = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*TOTAL_PREC-1:0]    req_a,
  input  logic [NUM_REQ*TOTAL_PREC-1:0]    req_b,
  output logic                             rsp_valid,
  output logic [$clog2(NUM_REQ)-1:0]       rsp_id,
  output logic [TOTAL_PREC-1:0]            rsp_res,
  output logic                             busy
);

  localparam int W   = TOTAL_PREC;
  localparam int F   = FRAC_BITS;
  localparam int IDW = $clog2(NUM_REQ);

  // The result chain holds the finished product.
  // With one stage, the product is formed combinationally from the granted
  // operands and is registered once.
  // With more stages, stage 0 holds the raw operands, and the result chain
  // covers stages 1..PIPE_STAGES-1.
  localparam int RES_STAGES = (PIPE_STAGES > 1) ? (PIPE_STAGES - 1) : 1;
  localparam int RES_OFS    = PIPE_STAGES - RES_STAGES;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Round-robin search. It starts at ptr and wraps from NUM_REQ-1 to 0.
  // Return value is {found, index}.
  function automatic logic [IDW:0] rr_pick_fn(input logic [NUM_REQ-1:0] valid,
                                              input logic [IDW-1:0]     ptr);
    logic [IDW:0] pick;
    int           cand;
    pick = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!pick[IDW] && valid[IDW'(cand)]) begin
        pick = {1'b1, IDW'(cand)};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

`ifdef FIXED_MULT_SAT_EN
  // Clamp the product when it is out of range.
  // hi is full[2W-1:F]. The result field is hi[W-1:0].
  // Bits hi[2W-F-1:W-1] are the sign-extension region, which is
  // full[2W-1:F+W-1]. That region must be all-equal for the product to fit.
  function automatic logic [W-1:0] sat_fn(input logic [2*W-F-1:0] hi);
    logic [W-F:0]  top;
    logic [W-1:0]  res;
    top = hi[2*W-F-1:W-1];
    if ((top == {(W-F+1){1'b0}}) || (top == {(W-F+1){1'b1}})) begin
      res = hi[W-1:0];
    end else if (hi[2*W-F-1]) begin
      res = {1'b1, {(W-1){1'b0}}};
    end else begin
      res = {1'b0, {(W-1){1'b1}}};
    end
    return res;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [IDW-1:0]     ptr_q;
  logic [IDW-1:0]     ptr_d;
  logic [IDW:0]       pick_s;
  logic               found_s;
  logic [IDW-1:0]     grant_idx_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               accept_s;
  logic [W-1:0]       sel_a_s;
  logic [W-1:0]       sel_b_s;

  // Pick the winning requester and build the one-hot grant.
  always_comb begin
    pick_s      = rr_pick_fn(req_valid, ptr_q);
    found_s     = pick_s[IDW];
    grant_idx_s = pick_s[IDW-1:0];
    if (found_s) begin
      grant_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      grant_s = '0;
    end
  end

  assign req_ready = grant_s;
  assign accept_s  = |(req_valid & grant_s);
  assign sel_a_s   = req_a[grant_idx_s*W +: W];
  assign sel_b_s   = req_b[grant_idx_s*W +: W];

  // Next pointer: the position after the winner on an accept, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_s) begin
      if (grant_idx_s == IDW'(NUM_REQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_s + IDW'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control: a valid bit and a requester tag for every stage.
  // The last stage drives the response outputs.
  // ---------------------------------------------------------------------------
  logic [PIPE_STAGES-1:0] vld_q;
  logic [IDW-1:0]         id_q [PIPE_STAGES];

  // Move valid bits and tags forward every cycle.
  // Tags load only behind a valid bit, so rsp_id holds between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        id_q[k] <= '0;
      end
    end else begin
      vld_q[0] <= accept_s;
      if (accept_s) begin
        id_q[0] <= grant_idx_s;
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        vld_q[k] <= vld_q[k-1];
        if (vld_q[k-1]) begin
          id_q[k] <= id_q[k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  logic [W-1:0]   mul_a_s;
  logic [W-1:0]   mul_b_s;
  logic           res_load_s;
  logic [2*W-1:0] full_s;
  logic [W-1:0]   res_s;
  logic           unused_s;

  if (PIPE_STAGES > 1) begin : g_opreg
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;

    // Stage 0: capture the granted operand pair on accept.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q <= '0;
        b_q <= '0;
      end else if (accept_s) begin
        a_q <= sel_a_s;
        b_q <= sel_b_s;
      end
    end

    assign mul_a_s    = a_q;
    assign mul_b_s    = b_q;
    assign res_load_s = vld_q[0];
  end else begin : g_opcomb
    assign mul_a_s    = sel_a_s;
    assign mul_b_s    = sel_b_s;
    assign res_load_s = accept_s;
  end

  // Sign-extend both operands to 2W bits.
  // The low 2W bits of the product are then the correct two's-complement
  // result, with no mixed signedness.
  assign full_s = {{W{mul_a_s[W-1]}}, mul_a_s} * {{W{mul_b_s[W-1]}}, mul_b_s};

`ifdef FIXED_MULT_SAT_EN
  assign res_s    = sat_fn(full_s[2*W-1:F]);
  assign unused_s = ^full_s[F-1:0];
`else
  assign res_s    = full_s[F+W-1:F];
  assign unused_s = ^{full_s[2*W-1:F+W], full_s[F-1:0]};
`endif

  logic [W-1:0] res_q [RES_STAGES];

  // Result chain.
  // The entry stage takes the finished product.
  // Later stages (retiming slack) follow the valid bit of the stage before.
  // Each register holds its value while no valid result passes through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RES_STAGES; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      if (res_load_s) begin
        res_q[0] <= res_s;
      end
      for (int k = 1; k < RES_STAGES; k++) begin
        if (vld_q[k+RES_OFS-1]) begin
          res_q[k] <= res_q[k-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid = vld_q[PIPE_STAGES-1];
  assign rsp_id    = id_q[PIPE_STAGES-1];
  assign rsp_res   = res_q[RES_STAGES-1];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_fixed_mult_arbiter.sv
// Directed testbench for fixed_mult_arbiter at its default parameters
// (4 requesters, Q5.22, 2 pipeline stages).
// Inputs change 1 ns after a rising edge. The combinational grant is sampled
// 1 ns after that. Registered outputs are sampled 1 ns after a rising edge.
module tb_fixed_mult_arbiter;

  localparam int NR  = 4;
  localparam int W   = 27;
  localparam int IDW = 2;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*W-1:0]   req_a;
  logic [NR*W-1:0]   req_b;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_res;
  logic              busy;

  int checks = 0;
  int errors = 0;

  fixed_mult_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'b0000; req_a = '0; req_b = '0;
    #2;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_res !== 27'h0000000) begin errors++; $display("FAIL reset_rsp_res: got %h want 0", rsp_res); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_idle: got %b want 0000", req_ready); end
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL reset_ready_single: got %b want 0100", req_ready); end
    req_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  // Pointer is 0 here. After this test it is 1.
  task automatic test_basic();
    set_op(0, 27'h0600000, 27'h0800000);
    req_valid = 4'b0001;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL basic_ready: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL basic_id: got %0d want 0", rsp_id); end
    checks++; if (rsp_res !== 27'h0C00000) begin errors++; $display("FAIL basic_res: got %h want 0c00000", rsp_res); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL basic_single_pulse: got %b want 0", rsp_valid); end
    checks++; if (rsp_res !== 27'h0C00000) begin errors++; $display("FAIL basic_res_hold: got %h want 0c00000", rsp_res); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", busy); end
  endtask

  // Pointer is 1 here. Requesters 0 and 1 are valid, so 1 must win.
  // After this test the pointer is 2.
  task automatic test_sign();
    set_op(1, 27'h7C00000, 27'h0200000);
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL sign_ready: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL sign_valid: got %b want 1", rsp_valid); end
    checks++; if (rsp_id !== 2'd1) begin errors++; $display("FAIL sign_id: got %0d want 1", rsp_id); end
    checks++; if (rsp_res !== 27'h7E00000) begin errors++; $display("FAIL sign_res: got %h want 7e00000", rsp_res); end
  endtask

  // Pointer is 2 here. Two accepts back to back, +8*4 then -8*4.
  // After this test the pointer is 0.
  task automatic test_overflow();
    logic [W-1:0] exp_pos;
    logic [W-1:0] exp_neg;
`ifdef FIXED_MULT_SAT_EN
    exp_pos = 27'h3FFFFFF;
    exp_neg = 27'h4000000;
`else
    exp_pos = 27'h0000000;
    exp_neg = 27'h0000000;
`endif
    set_op(2, 27'h2000000, 27'h1000000);
    set_op(3, 27'h6000000, 27'h1000000);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_ready0: got %b want 0100", req_ready); end
    tick();
    req_valid = 4'b1000;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL ovf_ready1: got %b want 1000", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== 2'd2) || (rsp_res !== exp_pos))
      begin errors++; $display("FAIL ovf_pos: got v=%b id=%0d res=%h want v=1 id=2 res=%h", rsp_valid, rsp_id, rsp_res, exp_pos); end
    tick();
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== 2'd3) || (rsp_res !== exp_neg))
      begin errors++; $display("FAIL ovf_neg: got v=%b id=%0d res=%h want v=1 id=3 res=%h", rsp_valid, rsp_id, rsp_res, exp_neg); end
    tick();
  endtask

  // Pointer is 0 here. All requesters stay valid for 8 cycles.
  // After this test the pointer is 0.
  task automatic test_rr_contention();
    logic [NR-1:0]  exp_grant [NR];
    logic [W-1:0]   exp_res   [NR];
    exp_grant = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_res   = '{27'h0400000, 27'h0800000, 27'h0C00000, 27'h1000000};
    set_op(0, 27'h0400000, 27'h0400000);
    set_op(1, 27'h0800000, 27'h0400000);
    set_op(2, 27'h0C00000, 27'h0400000);
    set_op(3, 27'h1000000, 27'h0400000);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        checks++; if (req_ready !== exp_grant[c % NR])
          begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", c, req_ready, exp_grant[c % NR]); end
      end
      tick();
      if (c <= 8) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_busy[%0d]: got %b want 1", c, busy); end
      end else begin
        checks++; if ((busy !== 1'b0) || (rsp_valid !== 1'b0))
          begin errors++; $display("FAIL rr_drain: got busy=%b v=%b want 0 0", busy, rsp_valid); end
      end
      if ((c >= 1) && (c <= 8)) begin
        checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== IDW'((c - 1) % NR)) || (rsp_res !== exp_res[(c - 1) % NR]))
          begin errors++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d res=%h want v=1 id=%0d res=%h",
                                   c, rsp_valid, rsp_id, rsp_res, (c - 1) % NR, exp_res[(c - 1) % NR]); end
      end
    end
  endtask

  // Pointer is 0 here. One accept from requester 0 moves it to 1.
  // Then only requesters 3 and 0 are valid.
  // After this test the pointer is 1.
  task automatic test_pointer_skip();
    req_valid = 4'b0001;
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    req_valid = 4'b1001;
    #1;
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_grant3: got %b want 1000", req_ready); end
    tick();
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_grant0: got %b want 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== 2'd3))
      begin errors++; $display("FAIL skip_rsp3: got v=%b id=%0d want v=1 id=3", rsp_valid, rsp_id); end
    tick();
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== 2'd0))
      begin errors++; $display("FAIL skip_rsp0: got v=%b id=%0d want v=1 id=0", rsp_valid, rsp_id); end
    tick();
  endtask

  // Pointer is 1 here. Requester 1 is accepted, which moves the pointer to 2.
  // Reset is then asserted while that operation is still in flight.
  task automatic test_midflight_reset();
    logic seen_valid;
    seen_valid = 1'b0;
    set_op(1, 27'h0400000, 27'h0400000);
    req_valid = 4'b0010;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mrst_pre_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    rst_n = 1'b0;
    #1;
    checks++; if ((rsp_valid !== 1'b0) || (rsp_id !== 2'd0) || (rsp_res !== 27'h0000000) || (busy !== 1'b0))
      begin errors++; $display("FAIL mrst_outputs: got v=%b id=%0d res=%h busy=%b want all 0", rsp_valid, rsp_id, rsp_res, busy); end
    for (int c = 0; c < 3; c++) begin
      tick();
      seen_valid = seen_valid | rsp_valid;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      seen_valid = seen_valid | rsp_valid;
    end
    checks++; if (seen_valid !== 1'b0) begin errors++; $display("FAIL mrst_no_rsp: got %b want 0", seen_valid); end
    req_valid = 4'b0110;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mrst_post_grant: got %b want 0010", req_ready); end
    tick();
    req_valid = 4'b0000;
    tick();
    checks++; if ((rsp_valid !== 1'b1) || (rsp_id !== 2'd1) || (rsp_res !== 27'h0400000))
      begin errors++; $display("FAIL mrst_post_rsp: got v=%b id=%0d res=%h want v=1 id=1 res=0400000", rsp_valid, rsp_id, rsp_res); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_overflow();
    test_rr_contention();
    test_pointer_skip();
    test_midflight_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
